// File: rtl/ac_economy_ctrl_pkg.sv
// ac_economy_ctrl_pkg
// Shared constants and types for the economy-mode AC controller:
//   - default sensor bank size for this home (window/door counts)
//   - default grace / resume hold-off delays
//   - FSM state encoding (IDLE=0, GRACE=1, AC_OFF=2, RESUME=3)
//   - max_int helper used to size the shared hold-off timer
package ac_economy_ctrl_pkg;

  localparam int HOME_WINDOW_COUNT       = 3;
  localparam int HOME_DOOR_COUNT         = 2;

  localparam int AC_OPEN_DELAY_DEFAULT   = 100;
  localparam int AC_RESUME_DELAY_DEFAULT = 50;

  typedef enum logic [1:0] {
    AC_ST_IDLE   = 2'd0,
    AC_ST_GRACE  = 2'd1,
    AC_ST_OFF    = 2'd2,
    AC_ST_RESUME = 2'd3
  } ac_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ac_economy_ctrl_if.sv
// ac_economy_ctrl_if
// Sensor-bank / AC-driver bundle for the economy-mode controller.
//   master : sensor side; drives eco enable, status and mask vectors,
//            observes the controller outputs
//   slave  : controller side; the mirror image
// Signals:
//   eco_mode_valid_i          economy mode enabled
//   WINDOW_STATUS_i / DOOR_STATUS_i   1 = opening is open
//   window_mask_i / door_mask_i       1 = ignore that opening
//   close_ac_o                1 = AC must be off (registered)
//   ac_off_evt_o / ac_on_evt_o        one-cycle event pulses
//   open_count_o              registered count of unmasked open openings
//   state_o                   FSM state for debug
interface ac_economy_ctrl_if
  import ac_economy_ctrl_pkg::*;
#(
  parameter int WINDOW_COUNT = HOME_WINDOW_COUNT,
  parameter int DOOR_COUNT   = HOME_DOOR_COUNT,
  parameter int OCNT_W       = $clog2(WINDOW_COUNT + DOOR_COUNT + 1)
);

  logic                    eco_mode_valid_i;
  logic [WINDOW_COUNT-1:0] WINDOW_STATUS_i;
  logic [DOOR_COUNT-1:0]   DOOR_STATUS_i;
  logic [WINDOW_COUNT-1:0] window_mask_i;
  logic [DOOR_COUNT-1:0]   door_mask_i;
  logic                    close_ac_o;
  logic                    ac_off_evt_o;
  logic                    ac_on_evt_o;
  logic [OCNT_W-1:0]       open_count_o;
  logic [1:0]              state_o;

  modport master (
    output eco_mode_valid_i, WINDOW_STATUS_i, DOOR_STATUS_i,
           window_mask_i, door_mask_i,
    input  close_ac_o, ac_off_evt_o, ac_on_evt_o, open_count_o, state_o
  );

  modport slave (
    input  eco_mode_valid_i, WINDOW_STATUS_i, DOOR_STATUS_i,
           window_mask_i, door_mask_i,
    output close_ac_o, ac_off_evt_o, ac_on_evt_o, open_count_o, state_o
  );

endinterface

// File: rtl/ac_holdoff_timer.sv
// ac_holdoff_timer
// Shared CNT_W-bit hold-off counter, used for both the open-grace and the
// resume hold-off intervals.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   clr_i         force count to zero (has priority over en_i)
//   en_i          advance count by one
//   limit_i       runtime terminal value
//   tc_o          count currently equals limit_i
// The count only advances while below limit_i, so it can never wrap.
module ac_holdoff_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q < limit_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/ac_economy_ctrl.sv
// ac_economy_ctrl
// Economy-mode AC controller. Forces the AC off once any unmasked window or
// door has stayed open for OPEN_DELAY_CYCLES, and releases it again only
// after RESUME_DELAY_CYCLES of everything closed.
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  synchronous reset, active-high
//   bus    ac_economy_ctrl_if.slave (sensor inputs, masks, AC control,
//          event pulses, open count, debug state)
module ac_economy_ctrl
  import ac_economy_ctrl_pkg::*;
#(
  parameter int WINDOW_COUNT        = HOME_WINDOW_COUNT,
  parameter int DOOR_COUNT          = HOME_DOOR_COUNT,
  parameter int OPEN_DELAY_CYCLES   = AC_OPEN_DELAY_DEFAULT,
  parameter int RESUME_DELAY_CYCLES = AC_RESUME_DELAY_DEFAULT,
  parameter int CNT_W  = $clog2(max_int(OPEN_DELAY_CYCLES, RESUME_DELAY_CYCLES) + 1),
  parameter int OCNT_W = $clog2(WINDOW_COUNT + DOOR_COUNT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ac_economy_ctrl_if.slave bus
);

  localparam int SENS_N = WINDOW_COUNT + DOOR_COUNT;
  localparam logic [CNT_W-1:0] OPEN_LIM   = CNT_W'(OPEN_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESUME_LIM = CNT_W'(RESUME_DELAY_CYCLES - 1);

  ac_state_e         state_q, state_d;
  logic              close_q;
  logic              off_evt_q, off_evt_d;
  logic              on_evt_q, on_evt_d;
  logic [OCNT_W-1:0] open_cnt_q, open_cnt_d;

  logic [SENS_N-1:0] open_vec;
  logic              open_any;

  logic              tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0]  tmr_limit;

  assign open_vec = {bus.WINDOW_STATUS_i & ~bus.window_mask_i,
                     bus.DOOR_STATUS_i   & ~bus.door_mask_i};
  assign open_any = |open_vec;

  always_comb begin
    open_cnt_d = '0;
    for (int i = 0; i < SENS_N; i++) begin
      open_cnt_d = open_cnt_d + OCNT_W'(open_vec[i]);
    end
  end

  // The single timer serves both counting states; the limit is chosen from
  // the current state only, which keeps tc free of any combinational loop.
  assign tmr_limit = (state_q == AC_ST_RESUME) ? RESUME_LIM : OPEN_LIM;

  ac_holdoff_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .tc_o    (tmr_tc)
  );

  // Timer is held clear except while GRACE or RESUME is still counting.
  always_comb begin
    state_d   = state_q;
    tmr_clr   = 1'b1;
    tmr_en    = 1'b0;
    off_evt_d = 1'b0;
    on_evt_d  = 1'b0;
    if (!bus.eco_mode_valid_i) begin
      state_d = AC_ST_IDLE;
    end else begin
      case (state_q)
        AC_ST_IDLE: begin
          if (open_any) state_d = AC_ST_GRACE;
        end
        AC_ST_GRACE: begin
          if (!open_any) begin
            state_d = AC_ST_IDLE;
          end else if (tmr_tc) begin
            state_d   = AC_ST_OFF;
            off_evt_d = 1'b1;
          end else begin
            tmr_clr = 1'b0;
            tmr_en  = 1'b1;
          end
        end
        AC_ST_OFF: begin
          if (!open_any) state_d = AC_ST_RESUME;
        end
        AC_ST_RESUME: begin
          // Re-opening goes straight back to AC_OFF: the AC never ran, so
          // there is no fresh grace period and no off event.
          if (open_any) begin
            state_d = AC_ST_OFF;
          end else if (tmr_tc) begin
            state_d  = AC_ST_IDLE;
            on_evt_d = 1'b1;
          end else begin
            tmr_clr = 1'b0;
            tmr_en  = 1'b1;
          end
        end
        default: state_d = AC_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= AC_ST_IDLE;
      close_q    <= 1'b0;
      off_evt_q  <= 1'b0;
      on_evt_q   <= 1'b0;
      open_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      close_q    <= (state_d == AC_ST_OFF) || (state_d == AC_ST_RESUME);
      off_evt_q  <= off_evt_d;
      on_evt_q   <= on_evt_d;
      open_cnt_q <= open_cnt_d;
    end
  end

  assign bus.close_ac_o   = close_q;
  assign bus.ac_off_evt_o = off_evt_q;
  assign bus.ac_on_evt_o  = on_evt_q;
  assign bus.open_count_o = open_cnt_q;
  assign bus.state_o      = state_q;

endmodule

// File: doc/ac_economy_ctrl.md
Name: ac_economy_ctrl

Overview:
- Parametrised, clocked economy-mode AC controller for the home-automation datapath. Sits between the window/door sensor bank and the AC driver.
- Per-sensor masking; an open-grace timer before forcing the AC off; a resume hold-off before re-enabling it.
- Produces a registered close_ac_o, one-cycle event pulses for the status/logging block, and a live count of unmasked open openings.

Parameters:
- WINDOW_COUNT, `HOME_WINDOW_COUNT: number of window sensors (>=1)
- DOOR_COUNT, `HOME_DOOR_COUNT: number of door sensors (>=1)
- OPEN_DELAY_CYCLES, 100: consecutive open cycles tolerated before AC is forced off (>=1)
- RESUME_DELAY_CYCLES, 50: consecutive all-closed cycles required before AC is released (>=1)
- CNT_W, $clog2(max(OPEN_DELAY_CYCLES,RESUME_DELAY_CYCLES)+1): timer width (derived)
- OCNT_W, $clog2(WINDOW_COUNT+DOOR_COUNT+1): open-count width (derived)

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- eco_mode_valid_i  in  1  economy mode enabled
- WINDOW_STATUS_i  in  WINDOW_COUNT  1 = window open, one bit per window
- DOOR_STATUS_i  in  DOOR_COUNT  1 = door open, one bit per door
- window_mask_i  in  WINDOW_COUNT  1 = ignore that window
- door_mask_i  in  DOOR_COUNT  1 = ignore that door
- close_ac_o  out  1  1 = AC must be off (registered)
- ac_off_evt_o  out  1  one-cycle pulse on entry to AC_OFF from GRACE
- ac_on_evt_o  out  1  one-cycle pulse on RESUME->IDLE release
- open_count_o  out  OCNT_W  registered popcount of unmasked open sensors
- state_o  out  2  current FSM state, for debug

Behaviour:
- Signal definitions:
  - open_vec = {WINDOW_STATUS_i & ~window_mask_i, DOOR_STATUS_i & ~door_mask_i}
  - open_any = |open_vec
  - All inputs are already synchronous to clk_i; they are not re-synchronised.
- Reset (rst_i=1 at an edge):
  - state=IDLE, timer=0, close_ac_o=0, ac_off_evt_o=0, ac_on_evt_o=0, open_count_o=0.
  - Reset mid-operation aborts any count; close_ac_o drops after that edge.
- FSM encoding: IDLE=2'd0, GRACE=2'd1, AC_OFF=2'd2, RESUME=2'd3.
- Priority order: rst_i, then !eco_mode_valid_i, then the per-state rules. Any state with eco_mode_valid_i=0 -> IDLE, timer=0, with no event pulse.
- Per-state rules:
  - IDLE: open_any -> GRACE, timer=0. Otherwise stay.
  - GRACE:
    - !open_any -> IDLE (grace aborted, no pulse).
    - Else if timer==OPEN_DELAY_CYCLES-1 -> AC_OFF, ac_off_evt_o=1 for one cycle.
    - Else timer+1.
  - AC_OFF: !open_any -> RESUME, timer=0. Otherwise stay.
  - RESUME:
    - open_any -> AC_OFF, timer=0. No new grace period; no ac_off_evt_o, since the AC never ran.
    - Else if timer==RESUME_DELAY_CYCLES-1 -> IDLE, ac_on_evt_o=1.
    - Else timer+1.
- close_ac_o: registered; equals 1 exactly when the next state is AC_OFF or RESUME.
- Latency:
  - Open first sampled at edge k and held -> close_ac_o rises after edge k+OPEN_DELAY_CYCLES.
  - All-closed first sampled at edge j -> close_ac_o falls after edge j+RESUME_DELAY_CYCLES.
- Simultaneous events:
  - A sensor closing while another opens keeps open_any=1, so there is no state change.
  - Mask changes take effect on the same edge they are sampled.
- Counter bounds: the timer never exceeds max(delay)-1 and never wraps.
- open_count_o: popcount(open_vec), registered every cycle regardless of state or eco mode. Its maximum is WINDOW_COUNT+DOOR_COUNT.
- Event pulses are mutually exclusive and never last longer than one cycle.

Decomposition:
- design_constant.vh:
  - Already holds HOME_WINDOW_COUNT and HOME_DOOR_COUNT.
  - Add AC_ST_IDLE/GRACE/OFF/RESUME state localparams and the default delay constants.
- One sub-module, ac_holdoff_timer: CNT_W-bit counter with clear, enable, and a terminal-count compare against a runtime limit. It is instantiated once and reused by GRACE and RESUME.
- Popcount stays inline as a combinational for-loop.

Test Plan (WINDOW_COUNT=3, DOOR_COUNT=2, OPEN_DELAY=4, RESUME=3):
- Reset mid-operation: in AC_OFF, assert rst_i for 1 cycle -> close_ac_o=0, state_o=0, open_count_o=0 after that edge.
- Grace expiry: eco=1, WINDOW_STATUS_i=3'b001 from edge k -> close_ac_o=1 after edge k+4; ac_off_evt_o=1 for exactly that cycle; open_count_o=1.
- Grace abort: window open for 3 edges, then closed -> close_ac_o stays 0, no pulse, state returns to 0.
- Resume hold-off:
  - From AC_OFF, close all at edge j -> close_ac_o=0 after edge j+3 and ac_on_evt_o pulses once.
  - Re-opening at edge j+1 instead -> back to AC_OFF with close_ac_o held at 1 and no ac_off_evt_o.
- Masking: DOOR_STATUS_i=2'b10 with door_mask_i=2'b10 for 10 cycles -> close_ac_o=0, open_count_o=0. Clearing the mask -> AC_OFF 4 edges later.
- Eco drop: in RESUME or AC_OFF, eco_mode_valid_i=0 -> state 0 and close_ac_o=0 after next edge, no event pulses. Re-enabling with a window open -> full 4-cycle grace restarts.
